rf_wb_ctrl: RTL and testbench
=============================

RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 64: register data width.
REQ-002 Parameter ADDR_WIDTH, default 5: register address width (32 registers).
REQ-003 Parameter FIFO_DEPTH, default 2: load-result buffer entries.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-006 alu_valid  in  1  ALU result present this cycle; no backpressure.
REQ-007 alu_addr / alu_data / alu_ppp  in  ADDR_WIDTH / DATA_WIDTH / 3  ALU destination, result, participation select.
REQ-008 ld_valid  in  1  load result offered.
REQ-009 ld_ready  out  1  load result accepted when ld_valid & ld_ready at the rising edge.
REQ-010 ld_addr / ld_data / ld_ppp  in  ADDR_WIDTH / DATA_WIDTH / 3  load destination, data, participation select.
REQ-011 wen  out  1  register-file write enable, registered.
REQ-012 wr_addr / data_in / PPP_sel  out  ADDR_WIDTH / DATA_WIDTH / 3  register-file write port, registered; bit 0 is MSB on all vectors.
REQ-013 pend_mask  out  32  bit r set = a buffered load targets register r.
REQ-014 fifo_cnt  out  2  number of buffered load entries.

Function
REQ-015 Valid PPP codes: 000 all bytes, 001 bits 0:31, 010 bits 32:63, 011 even bytes, 100 odd bytes; 101-111 are null.
REQ-016 A result is writable iff addr != 0 and PPP is valid; a non-writable result completes its handshake but never asserts wen and is never enqueued.
REQ-017 ld_ready = (fifo_cnt < FIFO_DEPTH), derived from registered count only; no same-cycle pass-through when full.
REQ-018 Write-port selection per cycle, priority: (1) writable ALU result; (2) FIFO head; (3) accepted writable load when FIFO empty (bypass); (4) none.
REQ-019 The selected result appears on wen/wr_addr/data_in/PPP_sel exactly 1 cycle after the sampling edge; wen deasserts in cycles with no selection.
REQ-020 When wen = 0, wr_addr/data_in/PPP_sel hold their last value.
REQ-021 An accepted writable load not selected in the same cycle is pushed at FIFO tail; pop and push in the same cycle are allowed and fifo_cnt is unchanged.
REQ-022 Loads leave the FIFO strictly in acceptance order; ALU results are never buffered.
REQ-023 A bypassed load (case 3) does not touch the FIFO and does not set pend_mask.
REQ-024 pend_mask is combinational from the FIFO valid entries; duplicate addresses set the bit once; the bit clears in the cycle after the last matching entry pops.
REQ-025 Counter and pointers wrap modulo FIFO_DEPTH; fifo_cnt never exceeds FIFO_DEPTH or underflows.

Reset
REQ-026 While reset = 0 at a rising edge: wen = 0, wr_addr = 0, data_in = 0, PPP_sel = 000, fifo_cnt = 0, all FIFO entries invalid.
REQ-027 During reset ld_ready = 0 and inputs are ignored; buffered entries are discarded on reset mid-operation.
REQ-028 In the first cycle after reset deasserts, ld_ready = 1 and pend_mask = 0.

Verification
REQ-029 ALU only: alu_valid=1, addr=5, data=64'h0123456789ABCDEF, ppp=000 -> next cycle wen=1, wr_addr=5, data_in=0123456789ABCDEF, PPP_sel=000.
REQ-030 Null drop: alu_addr=0 ppp=000, then alu_addr=3 ppp=110 -> wen stays 0 both cycles, outputs hold.
REQ-031 Collision: alu to r1 and load to r2 in the same cycle -> cycle+1 writes r1, fifo_cnt=1, pend_mask bit 2 set; cycle+2 writes r2, fifo_cnt=0, pend_mask=0.
REQ-032 Full: alu_valid held 1 for 4 cycles, loads to r7,r8,r9 offered -> r7,r8 accepted, ld_ready=0 while fifo_cnt=2, r9 accepted only after ALU stops; writes r7,r8,r9 in order.
REQ-033 Bypass: FIFO empty, no ALU, load r4 ppp=011 -> next cycle wen=1, wr_addr=4, PPP_sel=011, fifo_cnt=0.
REQ-034 Reset mid-operation: fifo_cnt=2, reset=0 for one edge -> wen=0, fifo_cnt=0, pend_mask=0, buffered loads never written.

Source files
------------

// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller.
// Merges an unstallable ALU result stream and a handshaked load stream onto a
// single registered register-file write port. ALU results have priority;
// loads that lose arbitration wait in a small in-order buffer.
module rf_wb_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [0:ADDR_WIDTH-1] alu_addr,
    input  logic [0:DATA_WIDTH-1] alu_data,
    input  logic [0:2]            alu_ppp,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [0:ADDR_WIDTH-1] ld_addr,
    input  logic [0:DATA_WIDTH-1] ld_data,
    input  logic [0:2]            ld_ppp,
    output logic                  wen,
    output logic [0:ADDR_WIDTH-1] wr_addr,
    output logic [0:DATA_WIDTH-1] data_in,
    output logic [0:2]            PPP_sel,
    output logic [0:31]           pend_mask,
    output logic [0:1]            fifo_cnt
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO,
        SRC_BYP
    } wb_src_e;

    // Load buffer storage
    logic [0:ADDR_WIDTH-1] fifo_addr [FIFO_DEPTH];
    logic [0:DATA_WIDTH-1] fifo_data [FIFO_DEPTH];
    logic [0:2]            fifo_ppp  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      cnt;

    logic                  alu_wr;
    logic                  ld_take;
    logic                  ld_wr;
    logic                  push;
    logic                  pop;
    wb_src_e               src;
    logic [0:ADDR_WIDTH-1] sel_addr;
    logic [0:DATA_WIDTH-1] sel_data;
    logic [0:2]            sel_ppp;

    // Register 0 is hard-wired and PPP codes above 100 select no bytes.
    function automatic logic is_writable(input logic [0:ADDR_WIDTH-1] a,
                                         input logic [0:2] p);
        return (a != '0) && (p <= 3'd4);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Readiness comes from the registered count only, and is forced low in reset.
    assign ld_ready = reset && (cnt < CNT_W'(FIFO_DEPTH));
    assign fifo_cnt = 2'(cnt);

    // Arbitration: ALU first, then buffered loads, then a same-cycle bypass.
    always_comb begin
        alu_wr  = alu_valid && is_writable(alu_addr, alu_ppp);
        ld_take = ld_valid && ld_ready;
        ld_wr   = ld_take && is_writable(ld_addr, ld_ppp);
        src     = SRC_NONE;
        push    = 1'b0;
        pop     = 1'b0;
        if (alu_wr) begin
            src  = SRC_ALU;
            push = ld_wr;
        end else if (cnt != '0) begin
            src  = SRC_FIFO;
            pop  = 1'b1;
            push = ld_wr;
        end else if (ld_wr) begin
            src  = SRC_BYP;
        end
    end

    // Write-port data mux for the selected source.
    always_comb begin
        sel_addr = alu_addr;
        sel_data = alu_data;
        sel_ppp  = alu_ppp;
        case (src)
            SRC_FIFO: begin
                sel_addr = fifo_addr[rd_ptr];
                sel_data = fifo_data[rd_ptr];
                sel_ppp  = fifo_ppp[rd_ptr];
            end
            SRC_BYP: begin
                sel_addr = ld_addr;
                sel_data = ld_data;
                sel_ppp  = ld_ppp;
            end
            default: ;
        endcase
    end

    // Registered write port; address/data/select hold while idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wen     <= 1'b0;
            wr_addr <= '0;
            data_in <= '0;
            PPP_sel <= '0;
        end else begin
            wen <= (src != SRC_NONE);
            if (src != SRC_NONE) begin
                wr_addr <= sel_addr;
                data_in <= sel_data;
                PPP_sel <= sel_ppp;
            end
        end
    end

    // Buffer pointers, occupancy and per-entry valid flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            fifo_vld <= '0;
        end else begin
            if (pop) begin
                fifo_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= ptr_inc(rd_ptr);
            end
            if (push) begin
                fifo_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Buffer payload; qualified by fifo_vld, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ld_addr;
            fifo_data[wr_ptr] <= ld_data;
            fifo_ppp[wr_ptr]  <= ld_ppp;
        end
    end

    // Pending-register mask: one bit per register targeted by a buffered load.
    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            for (int unsigned r = 0; r < 32; r++) begin
                if (fifo_vld[i] && (fifo_addr[i] == ADDR_WIDTH'(r)))
                    pend_mask[r] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Testbench for rf_wb_ctrl: queue-based reference model with a scoreboard
// monitor on the register-file write port.
module tb_rf_wb_ctrl;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [0:4]  alu_addr;
    logic [0:63] alu_data;
    logic [0:2]  alu_ppp;
    logic        ld_valid;
    logic        ld_ready;
    logic [0:4]  ld_addr;
    logic [0:63] ld_data;
    logic [0:2]  ld_ppp;
    logic        wen;
    logic [0:4]  wr_addr;
    logic [0:63] data_in;
    logic [0:2]  PPP_sel;
    logic [0:31] pend_mask;
    logic [0:1]  fifo_cnt;

    rf_wb_ctrl #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(5),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .alu_valid(alu_valid),
        .alu_addr(alu_addr),
        .alu_data(alu_data),
        .alu_ppp(alu_ppp),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .ld_ppp(ld_ppp),
        .wen(wen),
        .wr_addr(wr_addr),
        .data_in(data_in),
        .PPP_sel(PPP_sel),
        .pend_mask(pend_mask),
        .fifo_cnt(fifo_cnt)
    );

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
        logic [2:0]  p;
        int          c;
    } wr_t;

    wr_t exp_q[$];
    wr_t model_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    bit  rst_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter and reset-edge flag
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_seen = (reset == 1'b0);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit writable(input logic [4:0] a, input logic [2:0] p);
        return (a != 5'd0) && (p <= 3'd4);
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = 32'h0;
        foreach (model_q[i]) m |= 32'h8000_0000 >> model_q[i].a;
        return m;
    endfunction

    // One clock of stimulus: drive, check visible state, advance the model.
    task automatic step(input bit rn, input bit av, input logic [4:0] aa, input logic [63:0] ad,
                        input logic [2:0] ap, input bit lv, input logic [4:0] la,
                        input logic [63:0] ldd, input logic [2:0] lp, output bit acc);
        bit aw, lw;
        wr_t e;
        @(negedge clk);
        reset = rn; alu_valid = av; alu_addr = aa; alu_data = ad; alu_ppp = ap;
        ld_valid = lv; ld_addr = la; ld_data = ldd; ld_ppp = lp;
        #1;
        chk("fifo_cnt", fifo_cnt, model_q.size());
        chk("ld_ready", ld_ready, (rn && model_q.size() < DEPTH) ? 1 : 0);
        chk("pend_mask", pend_mask, model_mask());
        acc = 0;
        if (!rn) begin
            model_q.delete();
        end else begin
            acc = lv && (model_q.size() < DEPTH);
            aw = av && writable(aa, ap);
            lw = acc && writable(la, lp);
            if (aw) begin
                exp_q.push_back('{a: aa, d: ad, p: ap, c: cyc + 1});
                if (lw) model_q.push_back('{a: la, d: ldd, p: lp, c: 0});
            end else if (model_q.size() != 0) begin
                e = model_q.pop_front();
                e.c = cyc + 1;
                exp_q.push_back(e);
                if (lw) model_q.push_back('{a: la, d: ldd, p: lp, c: 0});
            end else if (lw) begin
                exp_q.push_back('{a: la, d: ldd, p: lp, c: cyc + 1});
            end
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(1, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    // Write-port monitor: pops the scoreboard whenever wen is seen.
    initial begin
        wr_t e;
        wr_t last;
        last = '{a: 0, d: 0, p: 0, c: 0};
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                chk("rst_wen", wen, 0);
                chk("rst_wr_addr", wr_addr, 0);
                chk("rst_data_in", data_in, 0);
                chk("rst_ppp_sel", PPP_sel, 0);
                last = '{a: 0, d: 0, p: 0, c: 0};
            end else if (wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d with no write expected (cycle %0d)",
                             wr_addr, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_cycle", cyc, e.c);
                    chk("wr_addr", wr_addr, e.a);
                    chk("data_in", data_in, e.d);
                    chk("ppp_sel", PPP_sel, e.p);
                    last = e;
                end
            end else begin
                chk("hold_wen", wen, 0);
                chk("hold_wr_addr", wr_addr, last.a);
                chk("hold_data_in", data_in, last.d);
                chk("hold_ppp_sel", PPP_sel, last.p);
            end
        end
    end

    initial begin
        bit acc;
        int idx;
        logic [4:0] lds[3];
        reset = 0; alu_valid = 0; alu_addr = 0; alu_data = 0; alu_ppp = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0; ld_ppp = 0;

        // Reset, then first cycle out of reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        step(0, 1, 5, 64'h1, 0, 1, 6, 64'h2, 0, acc);
        idle(1);

        // ALU-only write
        step(1, 1, 5, 64'h0123456789ABCDEF, 3'b000, 0, 0, 0, 0, acc);
        // Null results: register 0, then invalid PPP
        step(1, 1, 0, 64'hDEAD, 3'b000, 0, 0, 0, 0, acc);
        step(1, 1, 3, 64'hBEEF, 3'b110, 0, 0, 0, 0, acc);
        idle(2);

        // Collision: ALU to r1 and load to r2 together
        step(1, 1, 1, 64'h1111, 3'b001, 1, 2, 64'h2222, 3'b010, acc);
        idle(3);

        // Full buffer: ALU busy 4 cycles while loads r7, r8, r9 are offered
        lds[0] = 7; lds[1] = 8; lds[2] = 9;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, i < 4, 5'(10 + i), 64'(100 + i), 3'b000,
                 idx < 3, (idx < 3) ? lds[idx] : 5'd0, 64'(700 + idx), 3'b000, acc);
            if (acc) idx++;
        end
        chk("full_all_loads_accepted", idx, 3);
        idle(2);

        // Bypass with empty buffer
        step(1, 0, 0, 0, 0, 1, 4, 64'h4444, 3'b011, acc);
        idle(2);

        // Reset with two buffered loads
        step(1, 1, 20, 64'h20, 0, 1, 11, 64'hB1, 0, acc);
        step(1, 1, 21, 64'h21, 0, 1, 12, 64'hB2, 0, acc);
        step(1, 1, 22, 64'h22, 0, 0, 0, 0, 0, acc);
        step(0, 1, 23, 64'h23, 0, 1, 13, 64'hB3, 0, acc);
        idle(3);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 79) != 0,
                 $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)),
                 {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)),
                 {$urandom, $urandom}, 3'($urandom_range(0, 7)), acc);
        end

        idle(5);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
